// File: rtl/memfsm_pkg.sv
// memfsm_pkg: shared state encoding and bus widths for the memory read scanner.
package memfsm_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, LATCH, HOLD} state_t;
  localparam int MEM_AW = 16;
  localparam int MEM_DW = 18;
  localparam int DISP_W = 16;
endpackage

// File: rtl/step_conditioner.sv
// step_conditioner: synchronizes the step button and emits one-cycle advance pulses.
// Build option MEM_READ_DEBOUNCE_EN requires 2^16 stable cycles before an edge is seen.
module step_conditioner (
  input  logic clk,
  input  logic rst,
  input  logic step_i,
  output logic adv_o
);
  logic s1_q, s2_q, prev_q, clean;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= step_i;
      s2_q <= s1_q;
    end
`ifdef MEM_READ_DEBOUNCE_EN
  logic [15:0] cnt_q;
  logic stable_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (s2_q == stable_q) cnt_q <= '0;
    else if (&cnt_q) begin
      stable_q <= s2_q;
      cnt_q    <= '0;
    end else cnt_q <= cnt_q + 16'd1;
  assign clean = stable_q;
`else
  assign clean = s2_q;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) prev_q <= 1'b0;
    else prev_q <= clean;
  assign adv_o = clean & ~prev_q;
endmodule

// File: rtl/mem_read_scanner.sv
// mem_read_scanner: walks a memory window and latches each word for the SSD path.
// Build option MEM_READ_DEBOUNCE_EN enables step debouncing in step_conditioner.
module mem_read_scanner
  import memfsm_pkg::*;
#(
  parameter logic [MEM_AW-1:0] BASE_ADDR = 16'h0000,
  parameter int                LENGTH    = 16,
  parameter logic [23:0]       AUTO_DIV  = 24'd12_500_000,
  parameter int                RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              step,
  input  logic              auto_en,
  input  logic              rewind,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  input  logic [MEM_DW-1:0] mem_rdata,
  output logic [DISP_W-1:0] display,
  output logic              ovf,
  output logic [15:0]       index,
  output logic              busy
);
  localparam logic [15:0] LAST = 16'(LENGTH - 1);
  localparam logic [1:0]  LAT  = 2'(RD_LAT);
  state_t state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [15:0] idx_q, idx_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic ovf_q, ovf_d, busy_q, busy_d, rew_q, rew_d;
  logic [1:0] lat_q, lat_d;
  logic [23:0] timer_q, timer_d;
  logic step_adv, tick, adv_req, wrap;
  step_conditioner u_step (
    .clk   (clk),
    .rst   (clr),
    .step_i(step),
    .adv_o (step_adv)
  );
  assign tick    = auto_en && (timer_q == AUTO_DIV - 24'd1);
  assign timer_d = (!auto_en || tick) ? '0 : timer_q + 24'd1;
  assign adv_req = auto_en ? tick : step_adv;
  assign wrap    = idx_q == LAST;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    lat_d   = lat_q;
    rew_d   = rew_q | rewind;
    case (state_q)
      FETCH: begin
        busy_d  = 1'b1;
        lat_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d   = lat_q - 2'd1;
        state_d = (lat_q == 2'd1) ? LATCH : WAIT;
      end
      LATCH: begin
        disp_d  = mem_rdata[DISP_W-1:0];
        ovf_d   = |mem_rdata[MEM_DW-1:DISP_W];
        busy_d  = 1'b0;
        state_d = HOLD;
      end
      default: begin
        // a rewind seen while busy is held until here, then takes priority
        if (rewind || rew_q) begin
          state_d = FETCH;
          addr_d  = BASE_ADDR;
          idx_d   = '0;
          rew_d   = 1'b0;
        end else if (adv_req) begin
          state_d = FETCH;
          idx_d   = wrap ? 16'd0 : idx_q + 16'd1;
          addr_d  = wrap ? BASE_ADDR : BASE_ADDR + idx_q + 16'd1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state_q <= FETCH;
      addr_q  <= BASE_ADDR;
      idx_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      lat_q   <= '0;
      rew_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      lat_q   <= lat_d;
      rew_q   <= rew_d;
      timer_q <= timer_d;
    end
  assign mem_addr = addr_q;
  assign mem_we   = 1'b0;
  assign display  = disp_q;
  assign ovf      = ovf_q;
  assign index    = idx_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_mem_read_scanner.sv
// tb_mem_read_scanner: directed checks of three scanner instances (LENGTH 16, 4, 1) over a Fibonacci memory.
module tb_mem_read_scanner;
  logic clk, clr, step, auto_en, rewind;
  logic [15:0] a8, a4, a1, d8, d4, d1, i8, i4, i1;
  logic [17:0] rd8, rd4, rd1;
  logic we8, we4, we1, o8, o4, o1, b8, b4, b1;
  logic [17:0] mem [0:15];
  int vectors, errors;
  mem_read_scanner #(.BASE_ADDR(16'h0000), .LENGTH(16), .AUTO_DIV(24'd8), .RD_LAT(1)) dut (
    .clk(clk), .clr(clr), .step(step), .auto_en(auto_en), .rewind(rewind), .mem_addr(a8),
    .mem_we(we8), .mem_rdata(rd8), .display(d8), .ovf(o8), .index(i8), .busy(b8));
  mem_read_scanner #(.BASE_ADDR(16'h0000), .LENGTH(4), .AUTO_DIV(24'd8), .RD_LAT(1)) dut4 (
    .clk(clk), .clr(clr), .step(step), .auto_en(auto_en), .rewind(rewind), .mem_addr(a4),
    .mem_we(we4), .mem_rdata(rd4), .display(d4), .ovf(o4), .index(i4), .busy(b4));
  mem_read_scanner #(.BASE_ADDR(16'h0000), .LENGTH(1), .AUTO_DIV(24'd8), .RD_LAT(1)) dut1 (
    .clk(clk), .clr(clr), .step(step), .auto_en(auto_en), .rewind(rewind), .mem_addr(a1),
    .mem_we(we1), .mem_rdata(rd1), .display(d1), .ovf(o1), .index(i1), .busy(b1));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rd8 <= mem[a8[3:0]];
    rd4 <= mem[a4[3:0]];
    rd1 <= mem[a1[3:0]];
  end
  task automatic test_reset;
    clr = 1'b1; step = 1'b0; auto_en = 1'b0; rewind = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (a8 !== 16'd0) begin errors++; $display("FAIL rst_addr got %h exp 0000", a8); end
    vectors++; if (i8 !== 16'd0) begin errors++; $display("FAIL rst_index got %h exp 0000", i8); end
    vectors++; if (d8 !== 16'd0) begin errors++; $display("FAIL rst_display got %h exp 0000", d8); end
    vectors++; if (o8 !== 1'b0 || b8 !== 1'b0) begin errors++; $display("FAIL rst_ovf_busy got %b%b exp 00", o8, b8); end
    vectors++; if (we8 !== 1'b0) begin errors++; $display("FAIL mem_we got %b exp 0", we8); end
    clr = 1'b0;
    @(negedge clk);
    vectors++; if (b8 !== 1'b1 || a8 !== 16'd0) begin errors++; $display("FAIL first_fetch busy %b addr %h exp 1 0000", b8, a8); end
    repeat (2) @(negedge clk);
    vectors++; if (d8 !== 16'd0 || i8 !== 16'd0 || b8 !== 1'b0) begin errors++; $display("FAIL first_read disp %h idx %h busy %b exp 0000 0000 0", d8, i8, b8); end
  endtask
  task automatic pulse_step;
    step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
  endtask
  task automatic test_step;
    logic [15:0] old_d [0:2];
    logic [15:0] new_d [0:2];
    old_d = '{16'd0, 16'd1, 16'd1};
    new_d = '{16'd1, 16'd1, 16'd2};
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      repeat (5) @(negedge clk);
      vectors++; if (d8 !== old_d[i] || b8 !== 1'b1) begin errors++; $display("FAIL step%0d_early disp %h busy %b exp %h 1", i, d8, b8, old_d[i]); end
      @(negedge clk);
      vectors++; if (d8 !== new_d[i] || i8 !== 16'(i + 1) || b8 !== 1'b0) begin errors++; $display("FAIL step%0d disp %h idx %h busy %b exp %h %h 0", i, d8, i8, b8, new_d[i], 16'(i + 1)); end
      step = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic test_ovf_wrap;
    pulse_step;
    vectors++; if (d8 !== 16'd3 || i8 !== 16'd4) begin errors++; $display("FAIL step4 disp %h idx %h exp 0003 0004", d8, i8); end
    vectors++; if (i4 !== 16'd0 || a4 !== 16'd0 || d4 !== 16'd0) begin errors++; $display("FAIL wrap idx %h addr %h disp %h exp 0 0 0", i4, a4, d4); end
    pulse_step;
    vectors++; if (d8 !== 16'h0005 || o8 !== 1'b1) begin errors++; $display("FAIL ovf_set disp %h ovf %b exp 0005 1", d8, o8); end
    vectors++; if (i4 !== 16'd1 || d4 !== 16'd1) begin errors++; $display("FAIL after_wrap idx %h disp %h exp 1 1", i4, d4); end
    pulse_step;
    vectors++; if (d8 !== 16'h0008 || o8 !== 1'b0 || i8 !== 16'd6) begin errors++; $display("FAIL ovf_clr disp %h ovf %b idx %h exp 0008 0 6", d8, o8, i8); end
    vectors++; if (i1 !== 16'd0 || a1 !== 16'd0 || d1 !== 16'd0) begin errors++; $display("FAIL len1 idx %h addr %h disp %h exp 0 0 0", i1, a1, d1); end
  endtask
  task automatic test_drop;
    step = 1'b1; @(negedge clk);
    step = 1'b0; @(negedge clk);
    step = 1'b1; @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
    vectors++; if (i8 !== 16'd7 || d8 !== 16'd13) begin errors++; $display("FAIL drop idx %h disp %h exp 0007 000d", i8, d8); end
    vectors++; if (i4 !== 16'd3 || d4 !== 16'd2) begin errors++; $display("FAIL drop4 idx %h disp %h exp 0003 0002", i4, d4); end
  endtask
  task automatic test_rewind_pending;
    step = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 6) begin
        vectors++; if (i8 !== 16'd8 || d8 !== 16'd21) begin errors++; $display("FAIL rew_pre idx %h disp %h exp 0008 0015", i8, d8); end
      end
      if (c == 7) begin
        vectors++; if (i8 !== 16'd0 || a8 !== 16'd0) begin errors++; $display("FAIL rew_pend idx %h addr %h exp 0 0", i8, a8); end
      end
      if (c == 10) begin
        vectors++; if (d8 !== 16'd0 || b8 !== 1'b0) begin errors++; $display("FAIL rew_done disp %h busy %b exp 0 0", d8, b8); end
      end
      step = c < 2;
      rewind = c == 4;
    end
  endtask
  task automatic test_auto;
    auto_en = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 10) begin
        vectors++; if (i8 !== 16'd1 || d8 !== 16'd0) begin errors++; $display("FAIL auto_c10 idx %h disp %h exp 1 0", i8, d8); end
      end
      if (c == 11) begin
        vectors++; if (i8 !== 16'd1 || d8 !== 16'd1) begin errors++; $display("FAIL auto_c11 idx %h disp %h exp 1 1", i8, d8); end
      end
      if (c == 19) begin
        vectors++; if (i8 !== 16'd2 || d8 !== 16'd1) begin errors++; $display("FAIL auto_c19 idx %h disp %h exp 2 1", i8, d8); end
      end
      if (c == 27) begin
        vectors++; if (i8 !== 16'd3 || d8 !== 16'd2) begin errors++; $display("FAIL auto_c27 idx %h disp %h exp 3 2", i8, d8); end
      end
      if (c == 32) begin
        vectors++; if (i8 !== 16'd0 || a8 !== 16'd0) begin errors++; $display("FAIL rew_adv idx %h addr %h exp 0 0", i8, a8); end
      end
      step = (c % 3) == 0;
      rewind = c == 31;
    end
    step = 1'b0;
    repeat (6) @(negedge clk);
    auto_en = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (i8 !== 16'd0 || d8 !== 16'd0) begin errors++; $display("FAIL auto_end idx %h disp %h exp 0 0", i8, d8); end
  endtask
  task automatic test_clr_wait;
    pulse_step;
    step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1;
    vectors++; if (i8 !== 16'd0 || a8 !== 16'd0 || d8 !== 16'd0 || b8 !== 1'b0 || o8 !== 1'b0) begin errors++; $display("FAIL clr_wait idx %h addr %h disp %h busy %b ovf %b exp all 0", i8, a8, d8, b8, o8); end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    vectors++; if (b8 !== 1'b1 || a8 !== 16'd0) begin errors++; $display("FAIL clr_refetch busy %b addr %h exp 1 0", b8, a8); end
    repeat (2) @(negedge clk);
    vectors++; if (d8 !== 16'd0 || i8 !== 16'd0 || b8 !== 1'b0) begin errors++; $display("FAIL clr_reread disp %h idx %h busy %b exp 0 0 0", d8, i8, b8); end
  endtask
  task automatic test_debounce;
    step = 1'b1;
    repeat (100) @(negedge clk);
    step = 1'b0;
    repeat (200) @(negedge clk);
    vectors++; if (i8 !== 16'd0 || b8 !== 1'b0) begin errors++; $display("FAIL glitch idx %h busy %b exp 0 0", i8, b8); end
    step = 1'b1;
    repeat (65600) @(negedge clk);
    vectors++; if (i8 !== 16'd1 || d8 !== 16'd1) begin errors++; $display("FAIL debounced idx %h disp %h exp 1 1", i8, d8); end
  endtask
  initial begin
    logic [15:0] f [0:15];
    f = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610};
    for (int k = 0; k < 16; k++) mem[k] = {2'b00, f[k]};
    mem[5] = 18'h2_0005;
    vectors = 0;
    errors = 0;
    test_reset;
`ifdef MEM_READ_DEBOUNCE_EN
    test_debounce;
`else
    test_step;
    test_ovf_wrap;
    test_drop;
    test_rewind_pending;
    test_auto;
    test_clr_wait;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_read_scanner.md
Name: mem_read_scanner

Overview:
- Read-side counterpart to the Fibonacci writer FSM: walks a block of the dual-port memory and presents each stored word to the seven-segment path.
- Drives one memory read port (address only, write enable tied low).
- Advances on a button step or on an auto-scan timer.
- Outputs the 16-bit display word, an index and overflow flags to the SSD decoder.

Parameters:
- BASE_ADDR, 16'h0000, first memory address scanned
- LENGTH, 16, number of words in the scan window (1..65535)
- AUTO_DIV, 24'd12_500_000, clk cycles between auto-advances
- RD_LAT, 1, memory read latency in cycles (1 or 2)

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- step  in  1  raw push-button; rising edge requests the next word
- auto_en  in  1  1 = timer-driven advance, step ignored
- rewind  in  1  synchronous pulse; return to BASE_ADDR
- mem_addr  out  16  read address to memory port
- mem_we  out  1  constant 0
- mem_rdata  in  18  read data from memory port
- display  out  16  word to SSD decoder (mem_rdata[15:0])
- ovf  out  1  mem_rdata[17:16] != 0 for the displayed word
- index  out  16  offset of the displayed word (0..LENGTH-1)
- busy  out  1  read in flight

Behaviour:
- Async reset (clr=1): state=FETCH, mem_addr=BASE_ADDR, index=0, display=0, ovf=0, busy=0, timer=0, sync flops=0. Reset mid-read abandons the read.
- step is passed through a 2-flop synchronizer. An edge detector produces adv_req (one cycle) on a 0->1 transition of the synchronized step.
- When auto_en=1, adv_req instead fires when the timer reaches AUTO_DIV-1. The timer then clears.
- The timer holds at 0 while auto_en=0.
- States:
  - FETCH: drive mem_addr; busy=1; load latency counter with RD_LAT; go to WAIT.
  - WAIT: decrement latency counter; at 0 go to LATCH.
  - LATCH: display<=mem_rdata[15:0]; ovf<=|mem_rdata[17:16]; busy=0; go to HOLD.
  - HOLD: display stable. On adv_req go to FETCH with the next address. On rewind go to FETCH with BASE_ADDR.
- Address step: index<=index+1. If index==LENGTH-1, wrap index to 0 and mem_addr to BASE_ADDR. Otherwise mem_addr<=BASE_ADDR+index+1, computed mod 2^16.
- Latency from adv_req to display update is RD_LAT+2 cycles (RD_LAT=1: 3 cycles).
- adv_req arriving outside HOLD is dropped (no queueing).
- rewind and adv_req in the same HOLD cycle: rewind wins.
- rewind outside HOLD is latched and applied on entry to HOLD, giving an immediate re-FETCH of BASE_ADDR.
- LENGTH=1: every advance re-reads BASE_ADDR, and index stays 0.
- The first read after reset happens automatically, so display is valid RD_LAT+2 cycles after clr deasserts.

Optional Feature:
- MEM_READ_DEBOUNCE_EN
- Defined: the synchronized step must be stable for 2^16 clk cycles before the edge detector sees the change. A 16-bit counter restarts on any mismatch.
- Undefined: the synchronizer output feeds the edge detector directly, and each bounce edge may advance.

Decomposition:
- Shared package memfsm_pkg holds:
  - the state encoding (FETCH, WAIT, LATCH, HOLD, 2 bits)
  - MEM_AW=16 and MEM_DW=18
  - DISP_W=16
- Natural sub-module: step_conditioner, which contains the synchronizer, the optional debounce and the edge detector, and outputs one-cycle adv pulses.
- The timer and FSM stay in mem_read_scanner.

Test Plan:
- Reset then idle, memory preloaded with addr k -> value fib(k), BASE_ADDR=0, RD_LAT=1 -> mem_addr=0 during FETCH; display=16'h0000, index=0, busy=0 by cycle 3 after clr drops.
- Three step pulses spaced 10 cycles apart -> display sequence 1,1,2; index 1,2,3; each update exactly 3 cycles after the synchronized edge.
- LENGTH=4, five steps -> index 1,2,3,0,1; mem_addr wraps to BASE_ADDR; display returns to fib(0)=0 then 1.
- Word 18'h2_0005 at addr 5 -> display=16'h0005, ovf=1; next word 18'h0_0008 -> ovf=0.
- auto_en=1, AUTO_DIV=8 -> advance every 8 cycles regardless of step toggling. Then assert rewind together with adv_req -> mem_addr=BASE_ADDR, index=0.
- Assert clr during WAIT -> all outputs return to reset values immediately and the FETCH of BASE_ADDR restarts. With MEM_READ_DEBOUNCE_EN, a 100-cycle glitch on step -> no advance.
